// File: rtl/pair_packer.sv
// Packs consecutive DATA_WIDTH stream items into 2*DATA_WIDTH words for a dual-write FIFO.
// A flush pads an odd trailing item with PAD so nothing is left stranded in the packer.
module pair_packer #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           COUNT_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] PAD         = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    input  logic                    full,
    input  logic                    one_left,
    output logic                    wr,
    output logic [2*DATA_WIDTH-1:0] w_data,
    output logic                    busy,
    output logic [COUNT_WIDTH-1:0]  pair_count,
    output logic                    padded
);

    localparam int unsigned WORD_W = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        PAIR = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  lo_q, lo_d;
    logic [DATA_WIDTH-1:0]  hi_q, hi_d;
    logic                   padded_q, padded_d;
    logic [COUNT_WIDTH-1:0] pair_count_q, pair_count_d;

    logic space_ok;
    logic xfer;

    // A packed word needs two free FIFO slots; a same-cycle FIFO read is never assumed.
    assign space_ok = ~full & ~one_left;
    assign in_ready = ~reset & ((state_q != PAIR) | space_ok);
    assign wr       = ~reset & (state_q == PAIR) & space_ok;
    assign xfer     = in_valid & in_ready;

    assign w_data     = reset ? WORD_W'(0) : {hi_q, lo_q};
    assign busy       = (state_q != IDLE);
    assign pair_count = pair_count_q;
    assign padded     = padded_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lo_q         <= '0;
            hi_q         <= '0;
            padded_q     <= 1'b0;
            pair_count_q <= '0;
        end else begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            padded_q     <= padded_d;
            pair_count_q <= pair_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        padded_d     = padded_q;
        pair_count_d = pair_count_q;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    lo_d    = in_data;
                    state_d = HALF;
                end
            end
            HALF: begin
                // Data takes priority over a simultaneous flush; the flush is consumed.
                if (xfer) begin
                    hi_d     = in_data;
                    padded_d = 1'b0;
                    state_d  = PAIR;
                end else if (flush) begin
                    hi_d     = PAD;
                    padded_d = 1'b1;
                    state_d  = PAIR;
                end
            end
            PAIR: begin
                if (space_ok) begin
                    pair_count_d = pair_count_q + COUNT_WIDTH'(1);
                    if (xfer) begin
                        lo_d    = in_data;
                        state_d = HALF;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pair_packer.sv
// Self-checking bench for pair_packer: per-cycle vector table plus a scoreboard of packed words.
module tb_pair_packer;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;
    localparam logic [DW-1:0] PAD_V = 8'h00;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic          full;
    logic          one_left;
    logic          wr;
    logic [2*DW-1:0] w_data;
    logic          busy;
    logic [CW-1:0] pair_count;
    logic          padded;

    logic          w_in_ready, w_wr, w_busy, w_padded;
    logic [2*DW-1:0] w_w_data;
    logic [2:0]    w_pair_count;

    always #5 clk = ~clk;

    pair_packer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .PAD(PAD_V)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .full(full), .one_left(one_left), .wr(wr), .w_data(w_data),
        .busy(busy), .pair_count(pair_count), .padded(padded)
    );

    // Narrow counter copy so counter wrap is reachable in a short run.
    pair_packer #(.DATA_WIDTH(DW), .COUNT_WIDTH(3), .PAD(PAD_V)) u_wrap (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(w_in_ready),
        .flush(flush), .full(full), .one_left(one_left), .wr(w_wr), .w_data(w_w_data),
        .busy(w_busy), .pair_count(w_pair_count), .padded(w_padded)
    );

    typedef struct {
        bit          v;
        logic [7:0]  d;
        bit          fl;
        bit          fu;
        bit          ol;
        bit          er;
        bit          ew;
        bit          eb;
    } vec_t;

    typedef struct packed {
        logic [15:0] word;
        logic        pad;
    } exp_t;

    vec_t       tbl[$];
    exp_t       sb[$];
    logic       have_lo;
    logic [7:0] lo_m;
    int         n_vec = 0;
    int         n_err = 0;

    function automatic vec_t mk(bit v, logic [7:0] d, bit fl, bit fu, bit ol, bit er, bit ew, bit eb);
        vec_t r;
        r.v = v; r.d = d; r.fl = fl; r.fu = fu; r.ol = ol; r.er = er; r.ew = ew; r.eb = eb;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v.v; in_data = v.d; flush = v.fl; full = v.fu; one_left = v.ol;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(v.er));
        check("wr", 32'(wr), 32'(v.ew));
        check("busy", 32'(busy), 32'(v.eb));
        if (wr === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_unexpected: got w_data 0x%0h, expected no write at %0t", w_data, $time);
            end else begin
                e = sb.pop_front();
                check("w_data", 32'(w_data), 32'(e.word));
                check("padded", 32'(padded), 32'(e.pad));
            end
        end
        // Reference pairing built from what the bench drove
        if (v.v && v.er) begin
            if (have_lo) begin
                sb.push_back({v.d, lo_m, 1'b0});
                have_lo = 1'b0;
            end else begin
                lo_m    = v.d;
                have_lo = 1'b1;
            end
        end else if (v.fl && have_lo) begin
            sb.push_back({PAD_V, lo_m, 1'b1});
            have_lo = 1'b0;
        end
    endtask

    task automatic run(input int first, input int last);
        for (int i = first; i <= last; i++) apply(tbl[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; full = 1'b0; one_left = 1'b0;
        have_lo = 1'b0; lo_m = '0;

        //             v  data   fl fu ol er ew eb
        // back-to-back stream 0..5
        tbl.push_back(mk(H, 8'h11, L, L, L, H, L, L));
        tbl.push_back(mk(H, 8'h22, L, L, L, H, L, H));
        tbl.push_back(mk(H, 8'h33, L, L, L, H, H, H));
        tbl.push_back(mk(H, 8'h44, L, L, L, H, L, H));
        tbl.push_back(mk(L, 8'h00, L, L, L, H, H, H));
        tbl.push_back(mk(L, 8'h00, L, L, L, H, L, L));
        // flush pads an odd item, then flush in IDLE is ignored 6..10
        tbl.push_back(mk(H, 8'hA5, L, L, L, H, L, L));
        tbl.push_back(mk(L, 8'h00, H, L, L, H, L, H));
        tbl.push_back(mk(L, 8'h00, L, L, L, H, H, H));
        tbl.push_back(mk(L, 8'h00, H, L, L, H, L, L));
        tbl.push_back(mk(L, 8'h00, L, L, L, H, L, L));
        // backpressure in PAIR 11..13
        tbl.push_back(mk(H, 8'h01, L, L, L, H, L, L));
        tbl.push_back(mk(H, 8'h02, L, L, L, H, L, H));
        tbl.push_back(mk(H, 8'h03, L, L, H, L, L, H));
        // full plus an ignored flush in PAIR 14
        tbl.push_back(mk(H, 8'h03, H, H, L, L, L, H));
        // space returns: write and accept in the same cycle, then data+flush in HALF 15..19
        tbl.push_back(mk(H, 8'h03, L, L, L, H, H, H));
        tbl.push_back(mk(L, 8'h00, L, L, L, H, L, H));
        tbl.push_back(mk(H, 8'h7E, H, L, L, H, L, H));
        tbl.push_back(mk(L, 8'h00, L, L, L, H, H, H));
        tbl.push_back(mk(L, 8'h00, L, L, L, H, L, L));
        // park a pair 0xBBAA in PAIR under backpressure 20..22
        tbl.push_back(mk(H, 8'hAA, L, L, L, H, L, L));
        tbl.push_back(mk(H, 8'hBB, L, L, H, H, L, H));
        tbl.push_back(mk(L, 8'h00, L, L, H, L, L, H));

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_wr", 32'(wr), 32'(0));
        check("rst_w_data", 32'(w_data), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_pair_count", 32'(pair_count), 32'(0));
        check("rst_padded", 32'(padded), 32'(0));

        run(0, 5);
        check("pair_count_stream", 32'(pair_count), 32'(2));
        run(6, 10);
        check("pair_count_flush", 32'(pair_count), 32'(3));
        run(11, 13);
        check("w_data_hold_ol", 32'(w_data), 32'(16'h0201));
        run(14, 14);
        check("w_data_hold_full", 32'(w_data), 32'(16'h0201));
        run(15, 19);
        check("pair_count_mix", 32'(pair_count), 32'(5));
        check("wrap_count_mix", 32'(w_pair_count), 32'(5));
        run(20, 22);
        check("w_data_parked", 32'(w_data), 32'(16'hBBAA));

        // Reset while a word is parked with space available: it must never be written
        @(posedge clk);
        #1;
        reset = 1'b1; in_valid = 1'b0; full = 1'b0; one_left = 1'b0;
        sb.delete();
        have_lo = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'(0));
        check("midrst_wr", 32'(wr), 32'(0));
        check("midrst_w_data", 32'(w_data), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("postrst_busy", 32'(busy), 32'(0));
        check("postrst_pair_count", 32'(pair_count), 32'(0));
        check("postrst_in_ready", 32'(in_ready), 32'(1));
        check("postrst_wr", 32'(wr), 32'(0));

        // Eight full-rate pairs; the 3-bit counter copy wraps 7 -> 0
        for (int i = 0; i < 16; i++)
            apply(mk(H, 8'($urandom_range(255)), L, L, L, H, bit'(i >= 2 && (i % 2) == 0), bit'(i > 0)));
        apply(mk(L, 8'h00, L, L, L, H, H, H));
        check("pair_count_7", 32'(pair_count), 32'(7));
        check("wrap_count_7", 32'(w_pair_count), 32'(7));
        apply(mk(L, 8'h00, L, L, L, H, L, L));
        check("pair_count_8", 32'(pair_count), 32'(8));
        check("wrap_count_0", 32'(w_pair_count), 32'(0));

        check("scoreboard_empty", 32'(sb.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
